// File: rtl/mips_cycle_sequencer.sv
// mips_cycle_sequencer
// Multi-cycle control wrapper for a single-cycle MIPS datapath. Each
// instruction steps through FETCH -> EXEC -> (MEM) -> WB. Memory waits use
// req/ack handshakes. A wait longer than TIMEOUT cycles parks the block in a
// sticky ERROR state, which only reset can clear.
//
// Optional build macro: MIPS_SEQ_RETIRE_CNT_EN
//   Defined  : adds output retired_cnt[CNT_W-1:0], which counts WB cycles and wraps.
//   Undefined: the port and its counter are absent.
//
// Reset is asynchronous and active-low on port 'reset'.

module mips_cycle_sequencer #(
  parameter int TIMEOUT = 16,  // max cycles in one FETCH/MEM wait, >= 2
  parameter int CNT_W   = 32   // retired-instruction counter width
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             werf_in,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             werf,
  output logic             pc_en,
  output logic             busy,
  output logic             err,
  output logic [2:0]       state_dbg
`ifdef MIPS_SEQ_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_ERROR = 3'd7
  } state_t;

  // The wait counter only ever reaches TIMEOUT-1, so clog2 bits are enough.
  localparam int                WAIT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [WAIT_W-1:0]   w_wait_cnt_next;

  // State and wait-counter registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values. Blocking assignments here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
    end
  end

  // Next-state, wait-counter and output decode.
  // NOTE: every signal gets a default before the case. A path that leaves one
  // unassigned would infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_wait_cnt_next = r_wait_cnt;
    imem_req        = 1'b0;
    ir_load         = 1'b0;
    dmem_req        = 1'b0;
    dmem_we         = 1'b0;
    werf            = 1'b0;
    pc_en           = 1'b0;
    busy            = 1'b0;
    err             = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (run) begin
          w_next_state    = S_FETCH;
          w_wait_cnt_next = '0;
        end
      end

      S_FETCH: begin
        imem_req = 1'b1;
        busy     = 1'b1;
        if (imem_ack) begin
          // An ack in the final allowed cycle still wins over the timeout.
          ir_load      = 1'b1;
          w_next_state = S_EXEC;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end

      S_EXEC: begin
        busy = 1'b1;
        if (mem_rd || mem_wr) begin
          w_next_state    = S_MEM;
          w_wait_cnt_next = '0;
        end else begin
          w_next_state = S_WB;
        end
      end

      S_MEM: begin
        dmem_req = 1'b1;
        // A decode with both rd and wr set is treated as a store.
        dmem_we  = mem_wr;
        busy     = 1'b1;
        if (dmem_ack) begin
          w_next_state = S_WB;
        end else if (r_wait_cnt == WAIT_LAST) begin
          w_next_state = S_ERROR;
        end else begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end

      S_WB: begin
        werf  = werf_in;
        pc_en = 1'b1;
        busy  = 1'b1;
        if (run) begin
          w_next_state    = S_FETCH;
          w_wait_cnt_next = '0;
        end else begin
          w_next_state = S_IDLE;
        end
      end

      S_ERROR: begin
        err = 1'b1;
      end

      default: begin
        // Unused encodings fall back to IDLE.
        w_next_state = S_IDLE;
      end
    endcase
  end

  assign state_dbg = r_state;

`ifdef MIPS_SEQ_RETIRE_CNT_EN
  logic [CNT_W-1:0] r_retired_cnt;

  // Count one retire per WB cycle. The count wraps naturally and holds in ERROR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired_cnt <= '0;
    end else if (r_state == S_WB) begin
      r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign retired_cnt = r_retired_cnt;
`else
  // CNT_W only sizes the optional counter. Keep it referenced in the base build.
  logic w_unused_cnt_w;
  assign w_unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// tb_mips_cycle_sequencer
// Directed tests for mips_cycle_sequencer, built with TIMEOUT=4 and CNT_W=4.
// Inputs change just after each falling edge. Outputs are sampled 1 time unit later.
// The retire-counter test is compiled only when MIPS_SEQ_RETIRE_CNT_EN is defined.

module tb_mips_cycle_sequencer;

  logic       clk;
  logic       reset;
  logic       run;
  logic       imem_ack;
  logic       dmem_ack;
  logic       mem_rd;
  logic       mem_wr;
  logic       werf_in;
  logic       imem_req;
  logic       ir_load;
  logic       dmem_req;
  logic       dmem_we;
  logic       werf;
  logic       pc_en;
  logic       busy;
  logic       err;
  logic [2:0] state_dbg;
`ifdef MIPS_SEQ_RETIRE_CNT_EN
  logic [3:0] retired_cnt;
`endif

  int total = 0;
  int bad   = 0;

  mips_cycle_sequencer #(
    .TIMEOUT (4),
    .CNT_W   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .imem_ack  (imem_ack),
    .dmem_ack  (dmem_ack),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .werf_in   (werf_in),
    .imem_req  (imem_req),
    .ir_load   (ir_load),
    .dmem_req  (dmem_req),
    .dmem_we   (dmem_we),
    .werf      (werf),
    .pc_en     (pc_en),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
`ifdef MIPS_SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as
  // {state_dbg, imem_req, ir_load, dmem_req, dmem_we, werf, pc_en, busy, err}.
  logic [10:0] obs;
  assign obs = {state_dbg, imem_req, ir_load, dmem_req, dmem_we, werf, pc_en, busy, err};

  localparam logic [10:0] E_IDLE   = {3'd0, 8'b0000_0000};
  localparam logic [10:0] E_FETCH  = {3'd1, 8'b1000_0010};
  localparam logic [10:0] E_FETCHA = {3'd1, 8'b1100_0010};
  localparam logic [10:0] E_EXEC   = {3'd2, 8'b0000_0010};
  localparam logic [10:0] E_MEMRD  = {3'd3, 8'b0010_0010};
  localparam logic [10:0] E_MEMWR  = {3'd3, 8'b0011_0010};
  localparam logic [10:0] E_WB_W   = {3'd4, 8'b0000_1110};
  localparam logic [10:0] E_WB_NW  = {3'd4, 8'b0000_0110};
  localparam logic [10:0] E_ERR    = {3'd7, 8'b0000_0001};

  task automatic test_reset();
    @(negedge clk);
    #1;
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL reset_hold obs=%b exp=%b", obs, E_IDLE);
    end
    // Active inputs must not move the block while reset is held.
    run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    #1;
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL reset_inputs obs=%b exp=%b", obs, E_IDLE);
    end
    @(negedge clk);
    run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL reset_release obs=%b exp=%b", obs, E_IDLE);
    end
  endtask

  task automatic test_alu();
    logic [10:0] seq [11];
    int ir_cnt = 0;
    int pc_cnt = 0;
    seq = '{E_IDLE, E_FETCHA, E_EXEC, E_WB_W, E_FETCHA, E_EXEC, E_WB_W,
            E_FETCHA, E_EXEC, E_WB_W, E_IDLE};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        // dmem_ack is held high to show that no MEM state is entered.
        run = 1'b1; imem_ack = 1'b1; dmem_ack = 1'b1;
        mem_rd = 1'b0; mem_wr = 1'b0; werf_in = 1'b1;
      end
      if (i == 9) run = 1'b0;
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL alu c%0d obs=%b exp=%b", i, obs, seq[i]);
      end
      if (ir_load) ir_cnt++;
      if (pc_en) pc_cnt++;
    end
    total++;
    if (ir_cnt !== 3) begin
      bad++;
      $display("FAIL alu_ir_load_count got=%0d exp=3", ir_cnt);
    end
    total++;
    if (pc_cnt !== 3) begin
      bad++;
      $display("FAIL alu_pc_en_count got=%0d exp=3", pc_cnt);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic test_load();
    logic [10:0] seq [11];
    seq = '{E_IDLE, E_FETCH, E_FETCH, E_FETCHA, E_EXEC, E_MEMRD, E_MEMRD,
            E_MEMRD, E_MEMRD, E_WB_W, E_IDLE};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; werf_in = 1'b1;
        imem_ack = 1'b0; dmem_ack = 1'b0;
      end
      if (i == 3) imem_ack = 1'b1;  // Stays high through MEM and is ignored there.
      if (i == 8) dmem_ack = 1'b1;  // Ack in the last allowed MEM cycle.
      if (i == 9) begin
        dmem_ack = 1'b0; run = 1'b0;
      end
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL load c%0d obs=%b exp=%b", i, obs, seq[i]);
      end
    end
    imem_ack = 1'b0; mem_rd = 1'b0;
  endtask

  task automatic test_store();
    logic [10:0] seq [11];
    seq = '{E_IDLE, E_FETCHA, E_EXEC, E_MEMWR, E_MEMWR, E_WB_NW,
            E_FETCHA, E_EXEC, E_MEMWR, E_WB_NW, E_IDLE};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run = 1'b1; mem_rd = 1'b0; mem_wr = 1'b1; werf_in = 1'b0;
        imem_ack = 1'b1; dmem_ack = 1'b0;
      end
      if (i == 4) dmem_ack = 1'b1;
      if (i == 5) begin
        // The second instruction decodes as both rd and wr, so it must be a store.
        dmem_ack = 1'b0; mem_rd = 1'b1;
      end
      if (i == 8) dmem_ack = 1'b1;
      if (i == 9) begin
        dmem_ack = 1'b0; run = 1'b0;
      end
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL store c%0d obs=%b exp=%b", i, obs, seq[i]);
      end
    end
    imem_ack = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  task automatic test_timeout();
    logic [10:0] seq_m [9];
    logic [10:0] seq_f [7];
    seq_m = '{E_IDLE, E_FETCHA, E_EXEC, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD,
              E_ERR, E_ERR};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; werf_in = 1'b1;
        imem_ack = 1'b1; dmem_ack = 1'b0;
      end
      if (i == 7) dmem_ack = 1'b1;  // A late ack must not leave ERROR.
      #1;
      total++;
      if (obs !== seq_m[i]) begin
        bad++;
        $display("FAIL timeout_mem c%0d obs=%b exp=%b", i, obs, seq_m[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL timeout_mem_clear obs=%b exp=%b", obs, E_IDLE);
    end
    @(negedge clk);
    reset = 1'b1; run = 1'b0; dmem_ack = 1'b0; imem_ack = 1'b0; mem_rd = 1'b0;

    seq_f = '{E_IDLE, E_FETCH, E_FETCH, E_FETCH, E_FETCH, E_ERR, E_ERR};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b1;
      #1;
      total++;
      if (obs !== seq_f[i]) begin
        bad++;
        $display("FAIL timeout_fetch c%0d obs=%b exp=%b", i, obs, seq_f[i]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_async_reset();
    logic [10:0] seq [4];
    seq = '{E_IDLE, E_FETCHA, E_EXEC, E_MEMRD};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; werf_in = 1'b1;
        imem_ack = 1'b1; dmem_ack = 1'b0;
      end
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL areset_pre c%0d obs=%b exp=%b", i, obs, seq[i]);
      end
    end
    // Assert reset in the middle of the MEM cycle, away from any clock edge.
    #2;
    reset = 1'b0;
    #1;
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL areset_immediate obs=%b exp=%b", obs, E_IDLE);
    end
    @(negedge clk);
    run = 1'b0; imem_ack = 1'b0; mem_rd = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL areset_after obs=%b exp=%b", obs, E_IDLE);
    end
  endtask

  task automatic test_run_drop();
    logic [10:0] seq [6];
    seq = '{E_IDLE, E_FETCHA, E_EXEC, E_WB_W, E_IDLE, E_IDLE};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; werf_in = 1'b1;
        imem_ack = 1'b1; dmem_ack = 1'b0;
      end
      if (i == 2) run = 1'b0;  // Dropped during EXEC.
      #1;
      total++;
      if (obs !== seq[i]) begin
        bad++;
        $display("FAIL run_drop c%0d obs=%b exp=%b", i, obs, seq[i]);
      end
    end
    imem_ack = 1'b0;
  endtask

`ifdef MIPS_SEQ_RETIRE_CNT_EN
  task automatic test_retire_cnt();
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (retired_cnt !== 4'd0) begin
      bad++;
      $display("FAIL cnt_reset got=%0d exp=0", retired_cnt);
    end
    @(negedge clk);
    reset = 1'b1;
    // Execute 17 ALU instructions: 51 cycles, with run dropped in the last WB.
    for (int i = 0; i < 53; i++) begin
      @(negedge clk);
      if (i == 0) begin
        run = 1'b1; mem_rd = 1'b0; mem_wr = 1'b0; werf_in = 1'b1;
        imem_ack = 1'b1; dmem_ack = 1'b0;
      end
      if (i == 51) run = 1'b0;
      #1;
      if (i == 49) begin
        total++;
        if (retired_cnt !== 4'd0) begin
          bad++;
          $display("FAIL cnt_wrap got=%0d exp=0", retired_cnt);
        end
      end
    end
    total++;
    if (retired_cnt !== 4'd1) begin
      bad++;
      $display("FAIL cnt_17 got=%0d exp=1", retired_cnt);
    end
    // A fetch timeout must leave the count unchanged.
    imem_ack = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) run = 1'b1;
    end
    #1;
    total++;
    if (retired_cnt !== 4'd1 || err !== 1'b1) begin
      bad++;
      $display("FAIL cnt_error_hold got=%0d err=%b exp=1 err=1", retired_cnt, err);
    end
    @(negedge clk);
    reset = 1'b0;
    run   = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    run      = 1'b0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    werf_in  = 1'b0;

    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_async_reset();
    test_run_drop();
`ifdef MIPS_SEQ_RETIRE_CNT_EN
    test_retire_cnt();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
